// File: rtl/l_ivector_pkg.sv
// Shared entry type and sizing helpers for the IVector indication queue.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package l_ivector_pkg;

  localparam int L_IVEC_METH_W = 32;
  localparam int L_IVEC_V_W    = 32;
  localparam int L_IVEC_DEPTH  = 4;
  localparam int L_IVEC_CNT_W  = 16;

  // One buffered say request at the default payload widths.
  typedef struct packed {
    logic [L_IVEC_METH_W-1:0] meth;
    logic [L_IVEC_V_W-1:0]    v;
  } ivec_entry_t;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // All-ones value a w-bit event counter saturates at.
  function automatic logic [63:0] cnt_sat(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/l_ivector_fifo.sv
// Synchronous DEPTH-entry FIFO; rd/wr pointers wrap modulo DEPTH, a count register separates full from empty.
// Latency: an entry written in cycle N appears on first in N+1; no write-to-read bypass.
// Backpressure: enq ignored while full (enq_rdy=0), deq ignored while empty (deq_rdy=0).
module l_ivector_fifo
  import l_ivector_pkg::*;
#(
  parameter int  DEPTH   = L_IVEC_DEPTH,
  parameter type entry_t = ivec_entry_t
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     enq,
  input  entry_t                   enq_dat,
  output logic                     enq_rdy,
  input  logic                     deq,
  output logic                     deq_rdy,
  output entry_t                   first,
  output logic [occ_w(DEPTH)-1:0]  count
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                OCC_W    = occ_w(DEPTH);
  localparam logic [OCC_W-1:0]  FULL_CNT = OCC_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_enq;
  logic             do_deq;

  assign enq_rdy = (count != FULL_CNT);
  assign deq_rdy = (count != '0);
  assign do_enq  = enq & enq_rdy;
  assign do_deq  = deq & deq_rdy;

  // Head is forced to zero while empty so stale storage never leaks out.
  assign first = deq_rdy ? mem[rd_ptr] : '0;

  // Storage array: contents are don't-care until counted valid, so no reset.
  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr] <= enq_dat;
  end

  // Pointer and occupancy bookkeeping; reset discards everything buffered.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l_ivector_queue.sv
// Buffers say requests in a FIFO and echoes the head onto ind_heard, with occupancy and saturating event counters.
// Latency: a say accepted in cycle N can fire ind_heard no earlier than N+1.
// Backpressure: say__RDY drops when full; the head is held until ind_heard__RDY and rule_enable are both high.
module l_ivector_queue
  import l_ivector_pkg::*;
#(
  parameter int METH_W = L_IVEC_METH_W,
  parameter int V_W    = L_IVEC_V_W,
  parameter int DEPTH  = L_IVEC_DEPTH,
  parameter int CNT_W  = L_IVEC_CNT_W
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    say__ENA,
  input  logic [METH_W-1:0]       say_meth,
  input  logic [V_W-1:0]          say_v,
  output logic                    say__RDY,
  output logic                    ind_heard__ENA,
  output logic [METH_W-1:0]       ind_heard_heard_meth,
  output logic [V_W-1:0]          ind_heard_heard_v,
  input  logic                    ind_heard__RDY,
  input  logic                    rule_enable,
  output logic                    rule_ready,
  output logic [occ_w(DEPTH)-1:0] occupancy,
  output logic [CNT_W-1:0]        say_count,
  output logic [CNT_W-1:0]        heard_count
);

  typedef struct packed {
    logic [METH_W-1:0] meth;
    logic [V_W-1:0]    v;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  entry_t enq_dat;
  entry_t head;
  logic   enq_rdy;
  logic   deq_rdy;
  logic   say_acc;

  assign enq_dat.meth = say_meth;
  assign enq_dat.v    = say_v;

  l_ivector_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .enq     (say__ENA),
    .enq_dat (enq_dat),
    .enq_rdy (enq_rdy),
    .deq     (ind_heard__ENA),
    .deq_rdy (deq_rdy),
    .first   (head),
    .count   (occupancy)
  );

  // Handshake gating: fire is purely combinational from head-valid, consumer ready and scheduler enable.
  assign say__RDY             = enq_rdy;
  assign say_acc              = say__ENA & enq_rdy;
  assign rule_ready           = deq_rdy & ind_heard__RDY;
  assign ind_heard__ENA       = rule_enable & rule_ready;
  assign ind_heard_heard_meth = head.meth;
  assign ind_heard_heard_v    = head.v;

  // Event counters hold at all-ones instead of wrapping.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      say_count   <= '0;
      heard_count <= '0;
    end else begin
      if (say_acc && (say_count != CNT_MAX))            say_count   <= say_count + 1'b1;
      if (ind_heard__ENA && (heard_count != CNT_MAX))   heard_count <= heard_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_l_ivector_queue.sv
// Self-checking bench for l_ivector_queue: directed vector table, random stream vs queue model, async reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_l_ivector_queue;

  localparam int DEPTH   = 4;
  localparam int OCC_W   = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              say__ENA;
  logic [31:0]       say_meth;
  logic [31:0]       say_v;
  logic              say__RDY;
  logic              ind_heard__ENA;
  logic [31:0]       ind_heard_heard_meth;
  logic [31:0]       ind_heard_heard_v;
  logic              ind_heard__RDY;
  logic              rule_enable;
  logic              rule_ready;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  say_count;
  logic [CNT_W-1:0]  heard_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of buffered {meth, v} plus saturating counters.
  logic [63:0] mq[$];
  int          msc;
  int          mhc;

  l_ivector_queue #(
    .METH_W (32),
    .V_W    (32),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .say__ENA             (say__ENA),
    .say_meth             (say_meth),
    .say_v                (say_v),
    .say__RDY             (say__RDY),
    .ind_heard__ENA       (ind_heard__ENA),
    .ind_heard_heard_meth (ind_heard_heard_meth),
    .ind_heard_heard_v    (ind_heard_heard_v),
    .ind_heard__RDY       (ind_heard__RDY),
    .rule_enable          (rule_enable),
    .rule_ready           (rule_ready),
    .occupancy            (occupancy),
    .say_count            (say_count),
    .heard_count          (heard_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        se;
    logic [31:0] m;
    logic [31:0] v;
    logic        hr;
    logic        re;
    logic        e_rdy;
    logic        e_rr;
    logic        e_ena;
    logic [31:0] e_m;
    logic [31:0] e_v;
    int          e_occ;
    int          e_sc;
    int          e_hc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic se, input int m, input int v, input logic hr, input logic re,
                              input logic e_rdy, input logic e_rr, input logic e_ena,
                              input int e_m, input int e_v, input int e_occ, input int e_sc, input int e_hc);
    vec_t r;
    r.se = se; r.m = m; r.v = v; r.hr = hr; r.re = re;
    r.e_rdy = e_rdy; r.e_rr = e_rr; r.e_ena = e_ena;
    r.e_m = e_m; r.e_v = e_v; r.e_occ = e_occ; r.e_sc = e_sc; r.e_hc = e_hc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic se, input logic [31:0] m, input logic [31:0] v, input logic hr, input logic re);
    say__ENA       = se;
    say_meth       = m;
    say_v          = v;
    ind_heard__RDY = hr;
    rule_enable    = re;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    mq.delete();
    msc = 0;
    mhc = 0;
  endtask

  // One clock against the model: drive after the edge, compare at the falling edge, then advance the model.
  task automatic mstep(input string tag, input logic se, input logic [31:0] m, input logic [31:0] v,
                       input logic hr, input logic re);
    logic        e_rdy;
    logic        e_rr;
    logic        e_ena;
    logic [63:0] hd;
    drive(se, m, v, hr, re);
    @(negedge CLK);
    e_rdy = (mq.size() < DEPTH);
    e_rr  = (mq.size() != 0) && hr;
    e_ena = re && e_rr;
    hd    = (mq.size() != 0) ? mq[0] : 64'd0;
    chk({tag, ".say_rdy"},   64'(say__RDY),             64'(e_rdy));
    chk({tag, ".rule_rdy"},  64'(rule_ready),           64'(e_rr));
    chk({tag, ".ena"},       64'(ind_heard__ENA),       64'(e_ena));
    chk({tag, ".meth"},      64'(ind_heard_heard_meth), 64'(hd[63:32]));
    chk({tag, ".v"},         64'(ind_heard_heard_v),    64'(hd[31:0]));
    chk({tag, ".occ"},       64'(occupancy),            64'(mq.size()));
    chk({tag, ".say_cnt"},   64'(say_count),            64'(msc));
    chk({tag, ".heard_cnt"}, 64'(heard_count),          64'(mhc));
    chk({tag, ".balance"},   64'(say_count) - 64'(heard_count), 64'(occupancy));
    if (e_ena) begin
      void'(mq.pop_front());
      if (mhc != CNT_MAX) mhc++;
    end
    if (se && e_rdy) begin
      mq.push_back({m, v});
      if (msc != CNT_MAX) msc++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Directed table: reset/idle, single echo, fill to full, full with simultaneous say+fire, wrap and drain.
    tbl.push_back(mk(0,  0,  0, 0, 1,  1, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(1,  5,  7, 1, 1,  1, 0, 0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 1, 1,  5,  7, 1, 1, 0));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 0, 0,  0,  0, 0, 1, 1));
    tbl.push_back(mk(1, 10, 20, 0, 1,  1, 0, 0,  0,  0, 0, 1, 1));
    tbl.push_back(mk(1, 11, 21, 0, 1,  1, 0, 0, 10, 20, 1, 2, 1));
    tbl.push_back(mk(1, 12, 22, 0, 1,  1, 0, 0, 10, 20, 2, 3, 1));
    tbl.push_back(mk(1, 13, 23, 0, 1,  1, 0, 0, 10, 20, 3, 4, 1));
    tbl.push_back(mk(1, 14, 24, 0, 1,  0, 0, 0, 10, 20, 4, 5, 1));
    tbl.push_back(mk(0,  0,  0, 0, 1,  0, 0, 0, 10, 20, 4, 5, 1));
    tbl.push_back(mk(0,  0,  0, 1, 0,  0, 1, 0, 10, 20, 4, 5, 1));
    tbl.push_back(mk(1, 15, 25, 1, 1,  0, 1, 1, 10, 20, 4, 5, 1));
    tbl.push_back(mk(1, 15, 25, 0, 1,  1, 0, 0, 11, 21, 3, 5, 2));
    tbl.push_back(mk(0,  0,  0, 1, 1,  0, 1, 1, 11, 21, 4, 6, 2));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 1, 1, 12, 22, 3, 6, 3));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 1, 1, 13, 23, 2, 6, 4));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 1, 1, 15, 25, 1, 6, 5));
    tbl.push_back(mk(0,  0,  0, 1, 1,  1, 0, 0,  0,  0, 0, 6, 6));

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].se, tbl[i].m, tbl[i].v, tbl[i].hr, tbl[i].re);
      @(negedge CLK);
      chk($sformatf("row%0d.say_rdy", i),   64'(say__RDY),             64'(tbl[i].e_rdy));
      chk($sformatf("row%0d.rule_rdy", i),  64'(rule_ready),           64'(tbl[i].e_rr));
      chk($sformatf("row%0d.ena", i),       64'(ind_heard__ENA),       64'(tbl[i].e_ena));
      chk($sformatf("row%0d.meth", i),      64'(ind_heard_heard_meth), 64'(tbl[i].e_m));
      chk($sformatf("row%0d.v", i),         64'(ind_heard_heard_v),    64'(tbl[i].e_v));
      chk($sformatf("row%0d.occ", i),       64'(occupancy),            64'(tbl[i].e_occ));
      chk($sformatf("row%0d.say_cnt", i),   64'(say_count),            64'(tbl[i].e_sc));
      chk($sformatf("row%0d.heard_cnt", i), 64'(heard_count),          64'(tbl[i].e_hc));
      @(posedge CLK);
      #1;
    end

    // Random stream against the model.
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      mstep($sformatf("rnd%0d", c), ($urandom_range(0, 99) < 60), $urandom, $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    // Drain whatever is left so every input is seen at the output.
    for (int c = 0; c < 2 * DEPTH; c++) mstep($sformatf("drain%0d", c), 1'b0, '0, '0, 1'b1, 1'b1);
    chk("drain.empty", 64'(mq.size()), 64'd0);

    // Asynchronous reset with three entries buffered.
    do_reset();
    mstep("ar.fill0", 1'b1, 32'h111, 32'h211, 1'b0, 1'b0);
    mstep("ar.fill1", 1'b1, 32'h112, 32'h212, 1'b0, 1'b0);
    mstep("ar.fill2", 1'b1, 32'h113, 32'h213, 1'b0, 1'b0);
    chk("ar.pre_occ", 64'(occupancy), 64'd3);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    #2;
    nRST = 1'b1;
    #1;
    chk("ar.occ",      64'(occupancy),       64'd0);
    chk("ar.ena",      64'(ind_heard__ENA),  64'd0);
    chk("ar.rule_rdy", 64'(rule_ready),      64'd0);
    chk("ar.say_rdy",  64'(say__RDY),        64'd1);
    chk("ar.say_cnt",  64'(say_count),       64'd0);
    chk("ar.head",     64'(ind_heard_heard_meth), 64'd0);
    @(negedge CLK);
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    mq.delete();
    msc = 0;
    mhc = 0;
    mstep("ar.say",  1'b1, 32'hAAA, 32'hBBB, 1'b1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge CLK);
    chk("ar.first_ena",  64'(ind_heard__ENA),       64'd1);
    chk("ar.first_meth", 64'(ind_heard_heard_meth), 64'h0AAA);
    chk("ar.first_v",    64'(ind_heard_heard_v),    64'h0BBB);
    @(posedge CLK);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
